fifo_mc: RTL
============

# fifo_mc

Multi-channel synchronous FIFO: NUM_CH independent logical queues, each DEPTH entries deep, statically partitioned out of one shared storage array, with a valid/ready push port and a valid/ready pop port that each carry a channel index. It is the multi-queue successor to the single-queue FIFO in common_cells. It sits in front of per-ID or per-virtual-channel arbiters so that one channel's backlog cannot block another channel's traffic.

## Interface
- NUM_CH, 4: number of logical channels, ≥1.
- DEPTH, 4: entries per channel, ≥1.
- DATA_WIDTH, 32: payload width when dtype is left at its default.
- FALL_THROUGH, 1'b0: an empty channel presents pushed data on the output in the same cycle.
- dtype, logic [DATA_WIDTH-1:0]: payload type.
- CH_W, derived, not overridden: NUM_CH>1 ? $clog2(NUM_CH) : 1.
- CNT_W, derived, not overridden: $clog2(DEPTH+1).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset, **synchronous, active-low**.
- flush_i  in  NUM_CH  per-channel flush mask.
- in_valid_i  in  1  push request.
- in_ch_i  in  CH_W  push channel.
- data_i  in  dtype  push payload.
- in_ready_o  out  1  push accepted.
- out_ch_i  in  CH_W  pop channel select.
- out_valid_o  out  1  selected channel has data.
- data_o  out  dtype  head entry of the selected channel.
- out_ready_i  in  1  pop request.
- full_o  out  NUM_CH  per-channel full.
- empty_o  out  NUM_CH  per-channel empty.
- usage_o  out  NUM_CH*CNT_W  per-channel entry count; channel c occupies bits [c*CNT_W +: CNT_W]; full-width, not truncated.

## Operation
- Each channel has a read pointer, a write pointer (range 0..DEPTH-1) and a count (range 0..DEPTH). Channel c stores entry p at address c*DEPTH+p.
- in_ready_o = valid channel & ~full_o[in_ch_i] & ~flush_i[in_ch_i].
- A push fires when in_valid_i & in_ready_o: write the entry, advance the write pointer, count +1.
- A full channel never accepts a push, even if it is popped in the same cycle.
- out_valid_o = valid channel & ~flush_i[out_ch_i] & (count>0 | bypass).
- A pop fires when out_valid_o & out_ready_i: advance the read pointer, count -1.
- Pointers wrap from DEPTH-1 to 0. DEPTH does not need to be a power of 2.
- Push and pop on different channels are fully independent.
- Push and pop on the same channel in the same cycle: both pointers advance and the count is unchanged.
- Bypass applies only when FALL_THROUGH=1, the channel is empty, and the push targets the pop channel:
  - data_o = data_i and out_valid_o = 1.
  - If the pop also fires, nothing is stored and the pointers and count hold.
- Flush of channel c: next cycle its pointers and count are 0. Any push or pop to c in the flush cycle is blocked through the ready/valid terms. Other channels are unaffected.
- A channel index ≥ NUM_CH forces in_ready_o=0 and out_valid_o=0. data_o then reads as '0.
- Storage writes only on a push. Its contents are not reset except as stated below.

## Timing
- Reset (rst_ni=0 at a clk_i edge) clears all pointers, all counts and the storage array. After reset:
  - empty_o = '1, full_o = '0, usage_o = '0.
  - out_valid_o = 0 (1 if FALL_THROUGH and a matching push is present).
  - in_ready_o = 1 for a valid in_ch_i.
  - data_o = '0.
- Reset asserted mid-traffic discards all contents at that edge. Handshakes in that cycle have no effect.
- Latency without bypass: data pushed at edge t is visible on data_o from cycle t+1 if its channel is selected and the entry is the head.
- full_o, empty_o and usage_o are registered-state decodes. They do not reflect same-cycle push, pop or bypass.
- Data transfers only when valid & ready. Valid does not depend on ready. in_ready_o depends combinationally on in_ch_i and flush_i. out_valid_o and data_o depend combinationally on out_ch_i.

## Configuration
- COMMON_CELLS_FIFO_MC_ALMOST_FULL_EN defined:
  - Adds parameter AF_THRESH (default DEPTH-1).
  - Adds output almost_full_o [NUM_CH], bit c = (count_c ≥ AF_THRESH), registered decode, reset value '0.
  - Elaboration error if AF_THRESH is 0 or greater than DEPTH.
- Undefined: neither the port nor the parameter exists, and no threshold logic is built.

## Structure
- Package fifo_mc_pkg holds:
  - ch_idx_w(n) and cnt_w(d) width functions, used for CH_W and CNT_W.
  - The usage slice helper function.
- Sub-module fifo_mc_ctrl, generated NUM_CH times, owns one channel:
  - Read and write pointers, count, wrap logic and flush.
  - Push/pop strobes in; pointers and full/empty/count out.
- The top level owns channel decode, storage, the bypass mux and handshakes.

## Test plan
- Reset, then push 0xA0..0xA3 to ch1 at 1 per cycle:
  - full_o[1]=1 and usage ch1=4.
  - A 5th push sees in_ready_o=0.
  - Popping ch1 returns A0, A1, A2, A3 in order, then empty_o[1]=1.
- Interleave pushes to ch0 (0x10..) and ch2 (0x20..); pop ch2 only:
  - ch2 drains in order.
  - ch0 usage is unchanged and data_o on ch0 is still 0x10.
- DEPTH=3: 7 push/pop pairs on one channel with count held at 2:
  - The pointers wrap.
  - Output order matches input with no loss.
- flush_i[3] while ch3 holds 2 entries and ch0 holds 1, with a push to ch3 in the same cycle:
  - in_ready_o=0.
  - Next cycle usage ch3=0 and ch0 is intact.
- FALL_THROUGH=1, empty ch2, push 0x5A with out_ch_i=2 and out_ready_i=1:
  - Same cycle: data_o=0x5A and out_valid_o=1.
  - Next cycle: usage ch2=0.
- Assert rst_ni=0 for 1 cycle while all channels are half full:
  - All usage=0 and data_o='0.
  - The first push after reset is accepted.

Source files
------------

// File: rtl/fifo_mc_pkg.sv
// Shared definitions for the multi-channel FIFO: width helpers and the
// usage-vector slice helper used by fifo_mc and fifo_mc_ctrl.
package fifo_mc_pkg;

  // Per-channel count update selected each cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a per-channel count, which spans 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned d);
    return $clog2(d + 1);
  endfunction

  // Width of a per-channel pointer, which spans 0..DEPTH-1.
  function automatic int unsigned ptr_w(input int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  // Width of an address into the shared storage of n*d entries.
  function automatic int unsigned addr_w(input int unsigned n, input int unsigned d);
    return (n * d > 1) ? $clog2(n * d) : 1;
  endfunction

  // LSB of channel ch inside the packed usage vector.
  function automatic int unsigned usage_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/fifo_mc_ctrl.sv
// Bookkeeping for one logical channel of fifo_mc: read/write pointers with
// wrap at DEPTH-1, occupancy count, flush and full/empty decodes.
// Push and pop strobes arrive already qualified by the top level.
module fifo_mc_ctrl
  import fifo_mc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  cnt_op_e cnt_op;

  // Pointer successor; DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Decide how the count moves: simultaneous push and pop cancel out.
  always_comb begin
    // NOTE: default first so every path assigns cnt_op and no latch is inferred.
    cnt_op = CNT_HOLD;
    if (push_i && !pop_i) begin
      cnt_op = CNT_INC;
    end else if (pop_i && !push_i) begin
      cnt_op = CNT_DEC;
    end
  end

  // Pointer and count registers; reset and flush both return to empty.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (!rst_ni) begin
      wr_ptr_o <= '0;
      rd_ptr_o <= '0;
      count_o  <= '0;
    end else if (flush_i) begin
      wr_ptr_o <= '0;
      rd_ptr_o <= '0;
      count_o  <= '0;
    end else begin
      if (push_i) wr_ptr_o <= ptr_inc(wr_ptr_o);
      if (pop_i)  rd_ptr_o <= ptr_inc(rd_ptr_o);
      case (cnt_op)
        CNT_INC: count_o <= count_o + CNT_W'(1);
        CNT_DEC: count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);

endmodule

// File: rtl/fifo_mc.sv
// Multi-channel synchronous FIFO: NUM_CH independent queues of DEPTH entries
// carved statically out of one storage array (channel c, entry p lives at
// address c*DEPTH+p). One valid/ready push port and one valid/ready pop port,
// each steered by a channel index. Optional fall-through lets an empty channel
// forward the pushed word to the output in the same cycle.
// Optional feature macro: COMMON_CELLS_FIFO_MC_ALMOST_FULL_EN adds AF_THRESH
// and the per-channel almost_full_o output.
module fifo_mc
  import fifo_mc_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter bit          FALL_THROUGH = 1'b0,
`ifdef COMMON_CELLS_FIFO_MC_ALMOST_FULL_EN
  parameter int unsigned AF_THRESH    = DEPTH - 1,
`endif
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  localparam int unsigned CH_W        = ch_idx_w(NUM_CH),
  localparam int unsigned CNT_W       = cnt_w(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       flush_i,
  input  logic                    in_valid_i,
  input  logic [CH_W-1:0]         in_ch_i,
  input  dtype                    data_i,
  output logic                    in_ready_o,
  input  logic [CH_W-1:0]         out_ch_i,
  output logic                    out_valid_o,
  output dtype                    data_o,
  input  logic                    out_ready_i,
  output logic [NUM_CH-1:0]       full_o,
  output logic [NUM_CH-1:0]       empty_o,
`ifdef COMMON_CELLS_FIFO_MC_ALMOST_FULL_EN
  output logic [NUM_CH-1:0]       almost_full_o,
`endif
  output logic [NUM_CH*CNT_W-1:0] usage_o
);

  localparam int unsigned PTR_W     = ptr_w(DEPTH);
  localparam int unsigned ADDR_W    = addr_w(NUM_CH, DEPTH);
  localparam int unsigned MEM_DEPTH = NUM_CH * DEPTH;

  // One-hot channel selects; an out-of-range index yields an all-zero select,
  // which naturally closes both handshakes for that index.
  logic [NUM_CH-1:0] in_sel;
  logic [NUM_CH-1:0] out_sel;
  logic [NUM_CH-1:0] push_ch;
  logic [NUM_CH-1:0] pop_ch;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;

  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  logic push_fire;
  logic pop_fire;
  logic bypass;
  logic bypass_taken;

  dtype mem [MEM_DEPTH];

  // Decode channel indices and pick the selected channels' storage addresses.
  always_comb begin
    in_sel  = '0;
    out_sel = '0;
    wr_addr = '0;
    rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_sel[c]  = (int'(in_ch_i) == c);
      out_sel[c] = (int'(out_ch_i) == c);
      if (in_sel[c])  wr_addr = ADDR_W'(c * DEPTH) + ADDR_W'(wr_ptr[c]);
      if (out_sel[c]) rd_addr = ADDR_W'(c * DEPTH) + ADDR_W'(rd_ptr[c]);
    end
  end

  // Handshakes. A full channel refuses a push even if it is popped this cycle,
  // so in_ready_o never depends on out_ready_i.
  always_comb begin
    in_ready_o   = |(in_sel & ~full & ~flush_i);
    push_fire    = in_valid_i & in_ready_o;
    bypass       = FALL_THROUGH & push_fire & (|(in_sel & out_sel)) & (|(out_sel & empty));
    out_valid_o  = |(out_sel & ~flush_i & (~empty | {NUM_CH{bypass}}));
    pop_fire     = out_valid_o & out_ready_i;
    // A bypassed word that is consumed immediately never touches the channel.
    bypass_taken = bypass & pop_fire;
    push_ch      = in_sel  & {NUM_CH{push_fire & ~bypass_taken}};
    pop_ch       = out_sel & {NUM_CH{pop_fire  & ~bypass_taken}};
  end

  // Output mux: forwarded input word on bypass, otherwise the channel head.
  always_comb begin
    data_o = '0;
    if (|out_sel) begin
      data_o = bypass ? data_i : mem[rd_addr];
    end
  end

  // Shared storage; written only by an accepted, stored push.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: this array is cleared on reset on purpose so data_o reads '0
      // afterwards; storage that needs no defined content should skip this.
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (|push_ch) begin
      mem[wr_addr] <= data_i;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_mc_ctrl #(
      .DEPTH(DEPTH)
    ) u_ctrl (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i[c]),
      .push_i  (push_ch[c]),
      .pop_i   (pop_ch[c]),
      .wr_ptr_o(wr_ptr[c]),
      .rd_ptr_o(rd_ptr[c]),
      .count_o (count[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );

    assign usage_o[usage_lsb(c, CNT_W) +: CNT_W] = count[c];
  end

  assign full_o  = full;
  assign empty_o = empty;

`ifdef COMMON_CELLS_FIFO_MC_ALMOST_FULL_EN
  if (AF_THRESH == 0 || AF_THRESH > DEPTH) begin : g_af_bad_thresh
    $error("fifo_mc: AF_THRESH must lie in 1..DEPTH");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_af
    assign almost_full_o[c] = (count[c] >= CNT_W'(AF_THRESH));
  end
`endif

endmodule
